// File: rtl/output_port_scheduler_pkg.sv
// output_port_scheduler_pkg: shared port indices, crossbar select codes and grant helpers
package output_port_scheduler_pkg;

    localparam int PORT_X     = 0;
    localparam int PORT_Y     = 1;
    localparam int PORT_LOCAL = 2;

    localparam logic [2:0] SW_STOP  = 3'd0;
    localparam logic [2:0] SW_X1    = 3'd1;
    localparam logic [2:0] SW_Y1    = 3'd2;
    localparam logic [2:0] SW_LOCAL = 3'd3;

    function automatic logic [2:0] sw_code(input logic [2:0] g);
        return g[PORT_X] ? SW_X1 : g[PORT_Y] ? SW_Y1 : g[PORT_LOCAL] ? SW_LOCAL : SW_STOP;
    endfunction

    function automatic logic [1:0] next_ptr(input logic [2:0] g);
        return g[PORT_X] ? 2'd1 : g[PORT_Y] ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/output_port_scheduler_rr_arbiter3.sv
// rr_arbiter3: one-hot round-robin pick among three requests, searching from ptr upward
module rr_arbiter3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt
);

    logic [1:0] p0, p1, p2;

    // priority order ptr, ptr+1, ptr+2 (mod 3); an out-of-range ptr behaves as 0
    always_comb begin
        p0  = (ptr == 2'd3) ? 2'd0 : ptr;
        p1  = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
        p2  = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        gnt = req[p0] ? 3'b001 << p0 :
              req[p1] ? 3'b001 << p1 :
              req[p2] ? 3'b001 << p2 : 3'b000;
    end

endmodule

// File: rtl/output_port_scheduler.sv
// output_port_scheduler: wormhole packet-granular output allocation with downstream credit gating
module output_port_scheduler
    import output_port_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    req,
    input  logic [2:0]    tail,
    input  logic          credit_in,
    output logic [2:0]    grant,
    output logic [2:0]    sw,
    output logic          fire,
    output logic          busy,
    output logic [CW-1:0] credit_cnt,
    output logic          credit_err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q;
    logic [2:0]    grant_q, sw_q, arb_gnt;
    logic [1:0]    ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, cnt_full, has_credit;

    rr_arbiter3 u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    assign has_credit = cnt_q != '0;
    assign cnt_full   = cnt_q == CW'(DEPTH);
    assign fire       = en && state_q == LOCKED && |(grant_q & req) && has_credit;
    assign grant      = grant_q;
    assign sw         = sw_q;
    assign busy       = state_q == LOCKED;
    assign credit_cnt = cnt_q;
    assign credit_err = err_q;

    // free-slot count: a fire consumes, a returned credit restores, both together cancel
    always_comb begin
        cnt_d = (fire && !credit_in) ? cnt_q - CW'(1) :
                (credit_in && !fire && !cnt_full) ? cnt_q + CW'(1) : cnt_q;
    end

    // credit counter and sticky overflow flag run regardless of en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CW'(DEPTH);
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | (credit_in && !fire && cnt_full);
        end
    end

    // packet lock: grant a winner from IDLE, release after the owner's tail flit crosses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            sw_q    <= SW_STOP;
            ptr_q   <= 2'd0;
        end else if (en) begin
            case (state_q)
                IDLE: if (|req && has_credit) begin
                    state_q <= LOCKED;
                    grant_q <= arb_gnt;
                    sw_q    <= sw_code(arb_gnt);
                end
                LOCKED: if (fire && |(grant_q & tail)) begin
                    state_q <= IDLE;
                    grant_q <= 3'b000;
                    sw_q    <= SW_STOP;
                    ptr_q   <= next_ptr(grant_q);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_scheduler.sv
// tb_output_port_scheduler: directed stimulus with a fire scoreboard and inline state checks
module tb_output_port_scheduler;
    import output_port_scheduler_pkg::*;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b1, credit_in = 1'b0;
    logic [2:0] req = 3'b000, tail = 3'b000;
    logic [2:0] grant, sw;
    logic       fire, busy, credit_err;
    logic [3:0] credit_cnt;

    typedef struct packed {
        logic [2:0] g;
        logic [2:0] s;
    } exp_t;

    exp_t q[$];
    int   total = 0, passed = 0;

    output_port_scheduler #(.DEPTH(4), .CW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .tail       (tail),
        .credit_in  (credit_in),
        .grant      (grant),
        .sw         (sw),
        .fire       (fire),
        .busy       (busy),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input logic [2:0] g, input logic [2:0] s);
        for (int i = 0; i < n; i++) q.push_back('{g: g, s: s});
    endtask

    // scoreboard monitor: every flit transfer must match the next expected owner
    always @(negedge clk) begin
        if (!rst && fire) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_fire: got grant %0d expected no fire", grant);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("fire_grant", int'(grant), int'(e.g));
                chk("fire_sw", int'(sw), int'(e.s));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_sw", sw, SW_STOP);
        chk("rst_cnt", credit_cnt, 4);
        chk("rst_busy", busy, 0);
        chk("rst_err", credit_err, 0);
        chk("rst_fire", fire, 0);
        nxt();

        // round robin x, y, local, x with single-flit packets and credits echoed
        req = 3'b111; tail = 3'b111;
        push(1, 3'b001, SW_X1); push(1, 3'b010, SW_Y1);
        push(1, 3'b100, SW_LOCAL); push(1, 3'b001, SW_X1);
        for (int i = 0; i < 8; i++) begin
            #1 credit_in = fire;
            nxt();
        end
        req = 3'b000; credit_in = 1'b0;
        #1;
        chk("rr_cnt", credit_cnt, 4);
        chk("rr_err", credit_err, 0);
        chk("rr_busy", busy, 0);
        nxt();

        // local 3-flit packet while x waits (ptr=1 -> local wins)
        req = 3'b101; tail = 3'b001;
        push(3, 3'b100, SW_LOCAL); push(1, 3'b001, SW_X1);
        #1 chk("wh_c0_grant", grant, 0);
        nxt();
        #1 chk("wh_c1_grant", grant, 4); chk("wh_c1_busy", busy, 1); chk("wh_c1_fire", fire, 1);
        nxt();
        nxt();
        tail = 3'b101;
        #1 chk("wh_tail_fire", fire, 1);
        nxt();
        req = 3'b001; tail = 3'b001;
        #1 chk("wh_bubble_grant", grant, 0); chk("wh_bubble_busy", busy, 0);
        nxt();
        #1 chk("wh_x_grant", grant, 1); chk("wh_x_sw", sw, SW_X1);
        nxt();
        req = 3'b000; tail = 3'b000;
        #1 chk("wh_cnt", credit_cnt, 0); chk("wh_busy", busy, 0);
        credit_in = 1'b1;
        repeat (4) nxt();
        credit_in = 1'b0;
        #1 chk("refill_cnt", credit_cnt, 4); chk("refill_err", credit_err, 0);
        nxt();

        // 6-flit packet from y with no credit return: 4 fires then stall
        req = 3'b010; tail = 3'b000;
        push(6, 3'b010, SW_Y1);
        repeat (5) nxt();
        #1 chk("stall_fire", fire, 0); chk("stall_cnt", credit_cnt, 0);
        chk("stall_busy", busy, 1); chk("stall_grant", grant, 2);
        nxt();
        credit_in = 1'b1;
        #1 chk("stall_credit_fire", fire, 0);
        nxt();
        #1 chk("resume_fire1", fire, 1);
        nxt();
        credit_in = 1'b0; tail = 3'b010;
        #1 chk("resume_fire2", fire, 1);
        nxt();
        req = 3'b000; tail = 3'b000;
        #1 chk("stall_end_busy", busy, 0); chk("stall_end_grant", grant, 0);
        chk("stall_end_cnt", credit_cnt, 0);
        credit_in = 1'b1;
        nxt();
        nxt();
        credit_in = 1'b0;
        #1 chk("refill2_cnt", credit_cnt, 2);
        nxt();

        // fire and credit_in together for 5 cycles at cnt=2
        req = 3'b100; tail = 3'b000;
        push(5, 3'b100, SW_LOCAL);
        nxt();
        credit_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) tail = 3'b100;
            #1 chk("both_cnt", credit_cnt, 2);
            chk("both_fire", fire, 1);
            nxt();
        end
        req = 3'b000; tail = 3'b000;
        #1 chk("both_end_cnt", credit_cnt, 2); chk("both_end_busy", busy, 0);
        nxt();
        nxt();
        #1 chk("full_cnt", credit_cnt, 4); chk("full_err_pre", credit_err, 0);
        nxt();
        credit_in = 1'b0;
        #1 chk("ovf_err", credit_err, 1); chk("ovf_cnt", credit_cnt, 4);
        nxt();

        // en low while locked: no fire, grant held, credits still counted
        req = 3'b001; tail = 3'b000;
        push(2, 3'b001, SW_X1);
        nxt();
        #1 chk("en_first_fire", fire, 1);
        nxt();
        en = 1'b0; credit_in = 1'b1;
        #1 chk("en0_fire", fire, 0); chk("en0_grant", grant, 1);
        chk("en0_busy", busy, 1); chk("en0_cnt", credit_cnt, 3);
        nxt();
        credit_in = 1'b0;
        #1 chk("en0_credit_cnt", credit_cnt, 4); chk("en0_fire2", fire, 0); chk("en0_grant2", grant, 1);
        nxt();
        en = 1'b1; tail = 3'b001;
        #1 chk("en1_fire", fire, 1);
        nxt();
        req = 3'b000; tail = 3'b000;
        #1 chk("en_end_busy", busy, 0); chk("en_end_cnt", credit_cnt, 3);
        nxt();

        // reset mid-packet returns every output to reset values at once
        req = 3'b010;
        push(1, 3'b010, SW_Y1);
        nxt();
        #1 chk("mid_fire", fire, 1); chk("mid_grant", grant, 2);
        nxt();
        rst = 1'b1;
        #1;
        chk("mrst_grant", grant, 0);
        chk("mrst_sw", sw, SW_STOP);
        chk("mrst_busy", busy, 0);
        chk("mrst_fire", fire, 0);
        chk("mrst_cnt", credit_cnt, 4);
        chk("mrst_err", credit_err, 0);
        nxt();
        rst = 1'b0; req = 3'b000;
        nxt();
        nxt();
        chk("sb_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/output_port_scheduler.md
# output_port_scheduler

Per-output-port packet scheduler for the 3-port mesh router (x, y, local inputs). It arbitrates among the three input ports with round-robin priority and locks the output crossbar to the winner from head flit to tail flit (wormhole). It gates every flit transfer on a credit counter that tracks free slots in the downstream input buffer. One instance sits in front of each output port's crossbar select and replaces per-flit switch allocation with packet-granular allocation.

## Interface
- DEPTH, 4: downstream buffer depth in flits; credit counter reset value. Range 1..15.
- CW, 4: credit counter width; must satisfy 2^CW > DEPTH.
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  scheduler enable; when low, state, grant and pointer freeze
- req  in  3  per-input request: the flit at the input head targets this output; bit0=x, bit1=y, bit2=local
- tail  in  3  per-input: the flit at the input head is a tail (head+tail allowed = single-flit packet)
- credit_in  in  1  one downstream slot freed this cycle
- grant  out  3  registered one-hot owner of the output; 0 when idle
- sw  out  3  crossbar select: `SW_X1 / `SW_Y1 / `SW_LOCAL for the owner, `SW_STOP when idle
- fire  out  1  combinational: a flit crosses the switch this cycle (pop the owner input, push downstream)
- busy  out  1  output locked (state LOCKED)
- credit_cnt  out  CW  current free downstream slots
- credit_err  out  1  sticky: credit_in received while credit_cnt == DEPTH

## Operation
- States: IDLE, LOCKED. Reset -> IDLE.
- IDLE, en=1, req!=0, credit_cnt>0: choose the winner by round-robin starting at ptr (ptr, ptr+1, ptr+2 mod 3). Register grant=onehot(winner), sw=code(winner), go LOCKED. Otherwise stay IDLE, grant=0, sw=`SW_STOP.
- LOCKED: fire = en & |(grant & req) & (credit_cnt>0). Grant holds regardless of req; an owner that drops req only stalls the output (no preemption).
- fire with the owner's tail bit set -> IDLE next cycle. grant clears, sw=`SW_STOP, ptr = (winner+1) mod 3.
- IDLE always lasts at least one cycle between packets, so back-to-back packets on one output have a 1-cycle bubble.
- Credit: fire & !credit_in -> cnt-1; credit_in & !fire -> cnt+1; both -> unchanged. credit_in at cnt==DEPTH with no fire: cnt holds and credit_err sets (cleared only by rst). cnt never goes below 0, because fire requires cnt>0.
- Credit accounting ignores en (credit_in always counted). fire is 0 when en=0.
- Reset mid-packet: immediate return to the reset state. The partial packet is abandoned; the upstream/downstream buffers are reset by the same rst.
- Reset values: grant=0, sw=`SW_STOP, busy=0, fire=0, credit_cnt=DEPTH, credit_err=0, ptr=0 (x first), state IDLE.

## Timing
- req asserted in cycle N (IDLE, credits available) -> grant/sw valid in cycle N+1; first fire possible in N+1.
- Steady-state throughput is 1 flit/cycle while req=1 and credit_cnt>0.
- Tail fire in cycle M -> IDLE in M+1 -> next grant at the earliest M+2.
- credit_in in cycle N is visible in credit_cnt at N+1. A fire in N+1 may use that credit.
- The downstream must return credits with at least a 1-cycle round trip. No combinational path exists from credit_in to fire.

## Structure
- The SW_* crossbar codes and the port index constants (PORT_X=0, PORT_Y=1, PORT_LOCAL=2) belong in the shared global.v header. The state encoding stays local.
- Sub-module: rr_arbiter3, a 3-request round-robin picker (inputs req[2:0] and ptr[1:0], output onehot gnt[2:0]). It is reusable by the other per-port schedulers.
- The top instantiates rr_arbiter3 plus the FSM, the credit counter and the sw encoder.

## Test plan
- Reset, then idle: grant=0, sw=`SW_STOP, credit_cnt=4, busy=0. Assert rst mid-packet -> all outputs return to these values in the same cycle.
- All three req=1 with 1-flit packets, credits returned each cycle: grants follow x, y, local, x… with one IDLE cycle between each.
- Local sends a 3-flit packet (tail on the 3rd flit) while x requests: grant stays local for all 3 fires, then x is granted 2 cycles after the local tail fire.
- DEPTH=4, no credit_in, 6-flit packet: exactly 4 fires, credit_cnt=0, fire stalls. Return 2 credits -> 2 more fires, tail -> IDLE.
- Simultaneous fire and credit_in for 5 cycles at credit_cnt=2: credit_cnt stays 2. credit_in at cnt=4 with no fire -> credit_err=1 and cnt stays 4.
- en=0 during LOCKED with req=1 and credits available: fire=0, grant held. credit_in still increments credit_cnt.
